// File: rtl/frame_reader_pkg.sv
// frame_reader_pkg: state encoding, frame-geometry defaults and counter width helper
package frame_reader_pkg;
  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
  localparam int FRAME_PIXELS_DEF = 76800;
  localparam int H_PIXELS_DEF = 320;
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/frame_reader_fifo.sv
// frame_reader_fifo: first-word-fall-through FIFO with occupancy count
module frame_reader_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH = 16
) (
  input  logic                     in_clk,
  input  logic                     in_reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic we, re;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign we = push && (!full || pop);
  assign re = pop && !empty;
  assign head = mem[rd_ptr];
  always_ff @(posedge in_clk or posedge in_reset)
    if (in_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(we);
      rd_ptr <= rd_ptr + AW'(re);
      count <= count + (AW+1)'(we) - (AW+1)'(re);
    end
  always_ff @(posedge in_clk)
    if (we) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/sdram_frame_reader.sv
// sdram_frame_reader: streams frames from SDRAM reads into a valid/ready pixel stream.
// Define FRAME_READER_UNDERFLOW_CNT_EN to add the underflow_count output.
module sdram_frame_reader
  import frame_reader_pkg::*;
#(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16,
  parameter int FRAME_PIXELS = FRAME_PIXELS_DEF,
  parameter int H_PIXELS = H_PIXELS_DEF,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              in_clk,
  input  logic              in_reset,
  input  logic              in_start,
  output logic              read,
  output logic [ADDR_W-1:0] read_addr,
  input  logic              waitrequest,
  input  logic [DATA_W-1:0] readdata,
  input  logic              readdatavalid,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              busy,
`ifdef FRAME_READER_UNDERFLOW_CNT_EN
  output logic [15:0]       underflow_count,
`endif
  output logic [15:0]       frame_count
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = cnt_w(FRAME_PIXELS);
  localparam int HW = cnt_w(H_PIXELS);
  state_t state, state_n;
  logic [CW-1:0] pending, fifo_count, pend_n, cnt_n;
  logic [CW:0] credit_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] head;
  logic [PW-1:0] pix_cnt;
  logic [HW-1:0] col_cnt;
  logic acc, pop, empty, full, last_addr, want, read_n;
  assign acc = read && !waitrequest;
  assign last_addr = read_addr == ADDR_W'(FRAME_PIXELS - 1);
  assign pix_valid = !empty;
  assign pop = pix_valid && pix_ready;
  assign pix_data = pix_valid ? head : '0;
  assign pix_sof = pix_valid && pix_cnt == '0;
  assign pix_eol = pix_valid && col_cnt == HW'(H_PIXELS - 1);
  assign busy = state != IDLE;
  // Credit is judged on post-edge occupancy so outstanding + buffered never exceeds the FIFO.
  always_comb begin
    addr_n = acc ? (last_addr ? '0 : read_addr + ADDR_W'(1)) : read_addr;
    state_n = state == IDLE ? (in_start ? RUN : IDLE)
            : state == RUN  ? (in_start ? RUN : STOP)
            : (in_start && read_addr != '0) ? RUN
            : (read_addr == '0 && pending == '0 && empty && !read) ? IDLE : STOP;
    pend_n = pending + CW'(acc) - CW'(readdatavalid);
    cnt_n = fifo_count + CW'(readdatavalid) - CW'(pop);
    credit_n = {1'b0, pend_n} + {1'b0, cnt_n};
    want = state_n == RUN || (state_n == STOP && addr_n != '0);
    read_n = (read && waitrequest) || (want && credit_n < (CW+1)'(FIFO_DEPTH));
  end
  always_ff @(posedge in_clk or posedge in_reset)
    if (in_reset) begin
      state <= IDLE;
      read <= 1'b0;
      read_addr <= '0;
      pending <= '0;
      frame_count <= '0;
      pix_cnt <= '0;
      col_cnt <= '0;
    end else begin
      state <= state_n;
      read <= read_n;
      read_addr <= addr_n;
      pending <= pend_n;
      frame_count <= frame_count + 16'(acc && last_addr);
      if (pop) begin
        pix_cnt <= pix_cnt == PW'(FRAME_PIXELS - 1) ? '0 : pix_cnt + PW'(1);
        col_cnt <= col_cnt == HW'(H_PIXELS - 1) ? '0 : col_cnt + HW'(1);
      end
    end
  frame_reader_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .in_clk(in_clk),
    .in_reset(in_reset),
    .push(readdatavalid),
    .push_data(readdata),
    .pop(pop),
    .head(head),
    .empty(empty),
    .full(full),
    .count(fifo_count)
  );
`ifdef FRAME_READER_UNDERFLOW_CNT_EN
  logic seen;
  always_ff @(posedge in_clk or posedge in_reset)
    if (in_reset) begin
      seen <= 1'b0;
      underflow_count <= '0;
    end else begin
      seen <= state != IDLE && (seen || pix_valid);
      if (state == RUN && pix_ready && !pix_valid && seen && underflow_count != '1)
        underflow_count <= underflow_count + 16'd1;
    end
`endif
  rdv_ok: assert property (@(posedge in_clk) disable iff (in_reset)
    readdatavalid |-> (pending != '0 && !full));
endmodule

// File: tb/tb_sdram_frame_reader.sv
// tb_sdram_frame_reader: random-stall controller model plus in-order pixel scoreboard
module tb_sdram_frame_reader;
  localparam int FP = 1280;
  localparam int HP = 320;
  logic in_clk = 0, in_reset, in_start, read, waitrequest, readdatavalid;
  logic pix_valid, pix_ready, pix_sof, pix_eol, busy;
  logic [24:0] read_addr;
  logic [15:0] readdata, pix_data, frame_count;
`ifdef FRAME_READER_UNDERFLOW_CNT_EN
  logic [15:0] underflow_count;
`endif
  int n_chk = 0, n_pass = 0;
  int cyc = 0, last_due = 0, wr_pct = 0, max_extra = 0, hold_rdv = 0, accepts = 0;
  int exp_idx = 0, exp_uf = 0, n, fc, a;
  bit uf_track = 0, seen = 0, stalled = 0;
  logic [24:0] stall_addr;
  logic [15:0] rq_data[$];
  int rq_due[$];

  sdram_frame_reader #(.FRAME_PIXELS(FP), .H_PIXELS(HP)) dut (
    .in_clk(in_clk), .in_reset(in_reset), .in_start(in_start),
    .read(read), .read_addr(read_addr), .waitrequest(waitrequest),
    .readdata(readdata), .readdatavalid(readdatavalid),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .busy(busy),
`ifdef FRAME_READER_UNDERFLOW_CNT_EN
    .underflow_count(underflow_count),
`endif
    .frame_count(frame_count));

  always #5 in_clk = ~in_clk;
  always @(posedge in_clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge in_clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_read"}, read, 0);
    chk({tag, "_addr"}, read_addr, 0);
    chk({tag, "_valid"}, pix_valid, 0);
    chk({tag, "_data"}, pix_data, 0);
    chk({tag, "_sof"}, pix_sof, 0);
    chk({tag, "_eol"}, pix_eol, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_fcnt"}, frame_count, 0);
  endtask

  // Controller model and output scoreboard; everything here is stable at the falling edge.
  always @(negedge in_clk) begin
    if (in_reset) begin
      rq_data.delete();
      rq_due.delete();
      readdatavalid = 0;
      waitrequest = 0;
      stalled = 0;
      last_due = 0;
    end else begin
      if (stalled) begin
        chk("stall_read", read, 1);
        chk("stall_addr", read_addr, stall_addr);
      end
      if (pix_valid && pix_ready) begin
        chk("pix_data", pix_data, exp_idx);
        chk("pix_sof", pix_sof, exp_idx == 0);
        chk("pix_eol", pix_eol, exp_idx % HP == HP - 1);
        exp_idx = (exp_idx + 1) % FP;
      end
      if (uf_track) begin
        if (pix_valid) seen = 1;
        else if (seen && pix_ready) exp_uf++;
      end
      if (hold_rdv > 0) begin
        hold_rdv--;
        readdatavalid = 0;
      end else if (rq_due.size() > 0 && rq_due[0] <= cyc + 1) begin
        readdatavalid = 1;
        readdata = rq_data.pop_front();
        void'(rq_due.pop_front());
      end else readdatavalid = 0;
      waitrequest = $urandom_range(99) < wr_pct;
      if (read && !waitrequest) begin
        int d;
        d = cyc + 4 + int'($urandom_range(max_extra));
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        rq_data.push_back(read_addr[15:0]);
        rq_due.push_back(d);
        accepts++;
      end
      stalled = read && waitrequest;
      stall_addr = read_addr;
    end
  end

  initial begin
    in_reset = 1; in_start = 0; pix_ready = 1;
    waitrequest = 0; readdatavalid = 0; readdata = 0;
    repeat (3) step();
    chk_zero("reset");
    in_reset = 0;
    step();
    // zero-wait, fixed latency, with a 10-cycle response stall mid-frame
    uf_track = 1;
    in_start = 1;
    n = 0;
    while (!pix_valid && n < 20) begin step(); n++; end
    chk("first_latency", n, 5);
    chk("first_sof", pix_sof, 1);
    chk("first_data", pix_data, 0);
    repeat (200) step();
    hold_rdv = 10;
    n = 0;
    while (frame_count == 0 && n < 4000) begin step(); n++; end
    chk("wrap_fcnt", frame_count, 1);
    chk("wrap_addr", read_addr, 0);
`ifdef FRAME_READER_UNDERFLOW_CNT_EN
    chk("underflow", underflow_count, exp_uf);
`endif
    uf_track = 0;
    // sink stalled from the start: exactly FIFO_DEPTH requests
    in_reset = 1; in_start = 0; pix_ready = 0;
    step();
    in_reset = 0; exp_idx = 0; accepts = 0;
    step();
    in_start = 1;
    repeat (100) step();
    chk("full_accepts", accepts, 16);
    chk("full_read", read, 0);
    chk("full_valid", pix_valid, 1);
    chk("full_sof", pix_sof, 1);
    pix_ready = 1;
    n = 0;
    while (exp_idx < 16 && n < 100) begin step(); n++; end
    chk("drain16", exp_idx >= 16, 1);
    repeat (10) step();
    chk("resume", accepts > 16, 1);
    // random stalls and response delays over two frame wraps
    wr_pct = 50; max_extra = 3;
    fc = frame_count;
    n = 0;
    while (frame_count != 16'(fc + 2) && n < 20000) begin step(); n++; end
    chk("rand_frames", frame_count, 16'(fc + 2));
    // stop mid-frame: finish the frame, drain, go idle
    n = 0;
    while (read_addr != 1000 && n < 5000) begin step(); n++; end
    chk("reach_1000", read_addr, 1000);
    in_start = 0;
    fc = frame_count;
    n = 0;
    while (busy && n < 10000) begin step(); n++; end
    chk("stop_busy", busy, 0);
    chk("stop_fcnt", frame_count, 16'(fc + 1));
    chk("stop_addr", read_addr, 0);
    chk("stop_read", read, 0);
    chk("stop_valid", pix_valid, 0);
    chk("stop_drained", exp_idx, 0);
    a = accepts;
    repeat (20) step();
    chk("stop_quiet", accepts, a);
    // asynchronous reset mid-frame, then restart from pixel 0
    in_start = 1;
    n = 0;
    while (read_addr != 500 && n < 5000) begin step(); n++; end
    chk("reach_500", read_addr, 500);
    in_reset = 1;
    #1;
    chk_zero("mid_reset");
    exp_idx = 0;
    step();
    step();
    in_reset = 0;
    n = 0;
    while (!pix_valid && n < 200) begin step(); n++; end
    chk("restart_sof", pix_sof, 1);
    chk("restart_data", pix_data, 0);
    repeat (400) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sdram_frame_reader.md
Name: sdram_frame_reader

Overview:
- Read-side counterpart to the frame-buffer fill logic: streams a 320x240 frame from SDRAM towards the VGA pixel path.
- Waits for the fill-complete level, then issues sequential pipelined reads over the SDRAM controller's read port.
- Buffers returned words in a local FIFO and presents them as a valid/ready pixel stream with start-of-frame and end-of-line markers.
- Repeats frames continuously while enabled.

Parameters:
ADDR_W, 25, SDRAM word address width
DATA_W, 16, SDRAM/pixel data width
FRAME_PIXELS, 76800, words per frame (addresses 0..FRAME_PIXELS-1)
H_PIXELS, 320, pixels per line (used for pix_eol)
FIFO_DEPTH, 16, local buffer entries (power of 2, >=4)

Ports:
in_clk  in  1  system clock
in_reset  in  1  asynchronous, active-high reset
in_start  in  1  level; high = stream frames (driven by fill-complete done)
read  out  1  read request to SDRAM controller
read_addr  out  ADDR_W  word address of current request
waitrequest  in  1  controller stall; request accepted when read && !waitrequest
readdata  in  DATA_W  returned word
readdatavalid  in  1  readdata valid this cycle, in request order
pix_data  out  DATA_W  pixel word at FIFO head
pix_valid  out  1  FIFO non-empty
pix_ready  in  1  sink accepts pixel when pix_valid && pix_ready
pix_sof  out  1  head pixel is pixel 0 of a frame
pix_eol  out  1  head pixel is last of a line
busy  out  1  state != IDLE
frame_count  out  16  frames fully issued, wraps at 65535->0

Behaviour:
- Reset: all outputs 0, read_addr=0, state IDLE, FIFO empty, pending=0, output pixel/column counters 0.
- States: IDLE, RUN, STOP.
  - IDLE->RUN: when in_start=1.
  - RUN->STOP: when in_start=0 is sampled.
  - STOP->RUN: when in_start=1 and read_addr!=0.
  - STOP->IDLE: when read_addr==0 (frame boundary), pending==0 and FIFO empty.
- Issue: read=1 in RUN, and in STOP while read_addr!=0, provided pending+fifo_count < FIFO_DEPTH.
- Once asserted, read, read_addr and the request hold stable until accepted (Avalon rule). The credit condition is rechecked only after acceptance.
- On acceptance:
  - read_addr increments.
  - At FRAME_PIXELS-1, read_addr wraps to 0 and frame_count increments the same cycle.
- pending:
  - +1 on acceptance, -1 on readdatavalid, unchanged when both occur in the same cycle.
  - Width is clog2(FIFO_DEPTH)+1.
- readdatavalid: always written into the FIFO.
  - The credit rule guarantees no overflow.
  - readdatavalid with a full FIFO or with pending==0 is an error, flagged by a simulation assertion.
- Output:
  - pix_data/pix_valid come from the FIFO head, zero added latency; first-word-fall-through.
  - Pop on pix_valid && pix_ready.
  - Simultaneous push and pop on a full or empty FIFO is legal; the count stays consistent.
- Output counters advance on each pop:
  - Pixel counter wraps at FRAME_PIXELS-1.
  - Column counter wraps at H_PIXELS-1.
  - pix_sof = (pixel counter == 0) && pix_valid.
  - pix_eol = (column == H_PIXELS-1) && pix_valid.
- Minimum latency: in_start rising to first pix_valid = 2 cycles + controller read latency.
- Reset mid-operation: asynchronous clear of everything. Responses still in flight from the controller after reset are the system's responsibility; reset the controller together with this block.

Optional Feature:
- Macro: FRAME_READER_UNDERFLOW_CNT_EN.
- Defined:
  - Adds output port underflow_count (16 bits, saturating at 65535, reset 0).
  - Increments each cycle that state==RUN, pix_ready=1 and pix_valid=0, excluding cycles before the first pixel of the first frame after IDLE.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package frame_reader_pkg:
  - state enum (IDLE, RUN, STOP)
  - default constants FRAME_PIXELS=76800, H_PIXELS=320
  - localparam function for clog2-based counter widths
- Sub-module frame_reader_fifo: synchronous first-word-fall-through FIFO, DATA_W x FIFO_DEPTH, with count output. Used for the pixel buffer only.

Test Plan:
- Zero-wait controller, fixed 3-cycle read latency, pix_ready=1, in_start held high:
  - First pix_valid 5 cycles after in_start rise, with pix_sof=1.
  - pix_data equals the address pattern 0,1,2,...
  - pix_eol on pixels 319, 639, ...
  - frame_count=1 when read_addr wraps after address 76799.
- pix_ready=0 for 100 cycles:
  - Exactly FIFO_DEPTH(16) requests accepted, then read deasserts.
  - FIFO fills to 16 with no overflow.
  - Release pix_ready -> 16 pixels in order, then issuing resumes.
- Random waitrequest (50%) and random readdatavalid delays:
  - read_addr stable while stalled.
  - Output sequence is still gapless 0..76799, then wraps to 0 with pix_sof.
- in_start dropped at address 1000: reads continue to 76799, then read stops. After drain, busy falls. frame_count increments once.
- Assert in_reset mid-frame at address 500: all outputs 0 the same cycle. After release with in_start=1, reading restarts at address 0 with pix_sof.
- With FRAME_READER_UNDERFLOW_CNT_EN defined: stall readdatavalid 10 cycles mid-frame with pix_ready=1 -> underflow_count=10.
